// File: rtl/line_window_3row.sv
// line_window_3row: buffers the previous LEN-1 raster lines in circular line
// buffers and emits, per valid input pixel, a vertical column of LEN pixels
// with the vsync/hsync/reuse/valid sideband expected by the window stages.
module line_window_3row #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned LEN   = 3,
    parameter int unsigned IMG_W = 32
) (
    input  logic                    i_sclk,
    input  logic                    i_rst_n,
    input  logic                    i_vsync,
    input  logic                    i_hsync,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_tdata,
    output logic                    o_vsync,
    output logic                    o_hsync,
    output logic                    o_reuse,
    output logic                    o_valid,
    output logic signed [WIDTH-1:0] o_tdata [LEN-1:0],
    output logic                    o_err
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowFull = RW'(LEN - 1);

    logic [CW-1:0] col_q, col_d, wr_col;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          line_end;
    logic          row_full;
    logic          reuse_pend_q;

    // Line buffers: [0] holds the most recent complete line, [LEN-2] the oldest.
    logic signed [WIDTH-1:0] lb_mem [LEN-2:0][IMG_W-1:0];
    logic signed [WIDTH-1:0] lb_rd  [LEN-2:0];

    // Column/row bookkeeping: a sync pulse restarts the line before the pixel lands.
    always_comb begin
        wr_col   = (i_vsync || i_hsync) ? '0 : col_q;
        row_eff  = i_vsync ? '0 : row_q;
        col_d    = (i_vsync || i_hsync) ? '0 : col_q;
        row_d    = row_eff;
        line_end = i_valid && (wr_col == ColLast);
        row_full = (row_eff == RowFull);
        if (i_valid) begin
            if (wr_col == ColLast) begin
                col_d = '0;
                if (!row_full) begin
                    row_d = row_eff + RW'(1);
                end
            end else begin
                col_d = wr_col + CW'(1);
            end
        end
        for (int k = 0; k < int'(LEN) - 1; k++) begin
            lb_rd[k] = lb_mem[k][wr_col];
        end
    end

    // Line-buffer write: read-before-write shift of the column down the buffer chain.
    always_ff @(posedge i_sclk) begin
        if (i_valid) begin
            lb_mem[0][wr_col] <= i_tdata;
            for (int k = 1; k < int'(LEN) - 1; k++) begin
                lb_mem[k][wr_col] <= lb_rd[k-1];
            end
        end
    end

    // Counters, sideband pulses and sticky error flag.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            o_vsync      <= 1'b0;
            o_hsync      <= 1'b0;
            o_valid      <= 1'b0;
            reuse_pend_q <= 1'b0;
            o_reuse      <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            o_vsync      <= i_vsync;
            o_hsync      <= i_hsync && !i_vsync && (row_q == RowFull);
            o_valid      <= i_valid && row_full;
            // Line-end marker trails the final column by one cycle.
            reuse_pend_q <= line_end && row_full;
            o_reuse      <= reuse_pend_q;
            if (i_vsync) begin
                o_err <= 1'b0;
            end else if (i_hsync && (col_q != '0)) begin
                o_err <= 1'b1;
            end
        end
    end

    // Output column register; holds its value across non-valid cycles.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < int'(LEN); k++) begin
                o_tdata[k] <= '0;
            end
        end else if (i_valid) begin
            o_tdata[LEN-1] <= i_tdata;
            for (int k = 0; k < int'(LEN) - 1; k++) begin
                o_tdata[int'(LEN) - 2 - k] <= lb_rd[k];
            end
        end
    end

endmodule

// File: tb/tb_line_window_3row.sv
// Bench for line_window_3row (WIDTH=8, LEN=3, IMG_W=4, pixel = 10*row+col).
module tb_line_window_3row;

    localparam int WIDTH = 8;
    localparam int LEN   = 3;
    localparam int IMG_W = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    vs = 1'b0, hs = 1'b0, v = 1'b0;
    logic signed [WIDTH-1:0] d = '0;
    logic                    o_vsync, o_hsync, o_reuse, o_valid, o_err;
    logic signed [WIDTH-1:0] o_tdata [LEN-1:0];

    line_window_3row #(.WIDTH(WIDTH), .LEN(LEN), .IMG_W(IMG_W)) dut (
        .i_sclk  (clk),
        .i_rst_n (rst_n),
        .i_vsync (vs),
        .i_hsync (hs),
        .i_valid (v),
        .i_tdata (d),
        .o_vsync (o_vsync),
        .o_hsync (o_hsync),
        .o_reuse (o_reuse),
        .o_valid (o_valid),
        .o_tdata (o_tdata),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vs, hs, v;
        int d;
        bit ev, ct, evs, ehs, ereuse, eerr;
        int e2, e1, e0;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rec_n = 0;
    bit   reuse_nx = 0;
    bit   cur_err = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard: compare each expected record one cycle after it was driven.
    always @(posedge clk) begin
        vec_t r;
        #1;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk($sformatf("rec%0d.valid", rec_n), int'(o_valid), int'(r.ev));
            chk($sformatf("rec%0d.vsync", rec_n), int'(o_vsync), int'(r.evs));
            chk($sformatf("rec%0d.hsync", rec_n), int'(o_hsync), int'(r.ehs));
            chk($sformatf("rec%0d.reuse", rec_n), int'(o_reuse), int'(r.ereuse));
            chk($sformatf("rec%0d.err", rec_n), int'(o_err), int'(r.eerr));
            if (r.ct) begin
                chk($sformatf("rec%0d.tdata2", rec_n), int'(o_tdata[2]), r.e2);
                chk($sformatf("rec%0d.tdata1", rec_n), int'(o_tdata[1]), r.e1);
                chk($sformatf("rec%0d.tdata0", rec_n), int'(o_tdata[0]), r.e0);
            end
            rec_n++;
        end
    end

    task automatic add(bit avs, bit ahs, bit av, int ad, bit aev, bit act, bit aehs,
                       int a2, int a1, int a0, bit last);
        vec_t r;
        r.vs = avs; r.hs = ahs; r.v = av; r.d = ad;
        r.ev = aev; r.ct = act; r.evs = avs; r.ehs = aehs;
        r.e2 = a2; r.e1 = a1; r.e0 = a0;
        r.ereuse = reuse_nx;
        reuse_nx = last;
        r.eerr = cur_err;
        tbl.push_back(r);
    endtask

    task automatic pix(int r, int c, bit out, bit ct_en);
        add(0, 0, 1, 10*r + c, out, ct_en, 0, 10*r + c, 10*(r-1) + c, 10*(r-2) + c,
            out && (c == IMG_W - 1));
    endtask

    task automatic hsy(bit ehs);
        add(0, 1, 0, 0, 0, 0, ehs, 0, 0, 0, 0);
    endtask

    task automatic vsy();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame(int nrows);
        vsy();
        for (int r = 0; r < nrows; r++) begin
            hsy(r >= 2);
            for (int c = 0; c < IMG_W; c++) pix(r, c, r >= 2, r >= 2);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            vs = tbl[i].vs;
            hs = tbl[i].hs;
            v  = tbl[i].v;
            d  = WIDTH'(tbl[i].d);
            exp_q.push_back(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".valid"}, int'(o_valid), 0);
        chk({tag, ".vsync"}, int'(o_vsync), 0);
        chk({tag, ".hsync"}, int'(o_hsync), 0);
        chk({tag, ".reuse"}, int'(o_reuse), 0);
        chk({tag, ".err"}, int'(o_err), 0);
        for (int k = 0; k < LEN; k++) chk($sformatf("%s.tdata%0d", tag, k), int'(o_tdata[k]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full 4-line frame, back-to-back pixels after each hsync.
        frame(4);
        idle();
        run_tbl();

        // Row 2 with gaps: output column held across non-valid cycles.
        vsy();
        hsy(0);
        for (int c = 0; c < IMG_W; c++) pix(0, c, 0, 0);
        hsy(0);
        for (int c = 0; c < IMG_W; c++) pix(1, c, 0, 0);
        hsy(1);
        for (int c = 0; c < IMG_W; c++) begin
            pix(2, c, 1, 1);
            add(0, 0, 0, 0, 0, 1, 0, 20 + c, 10 + c, c, 0);
        end
        idle();
        run_tbl();

        // Short line 1: error, row count held, next full line acts as row 1.
        vsy();
        hsy(0);
        for (int c = 0; c < IMG_W; c++) pix(0, c, 0, 0);
        hsy(0);
        pix(1, 0, 0, 0);
        pix(1, 1, 0, 0);
        cur_err = 1;
        hsy(0);
        for (int c = 0; c < IMG_W; c++) pix(1, c, 0, 0);
        hsy(1);
        for (int c = 0; c < IMG_W; c++) pix(2, c, 1, c >= 2);
        hsy(1);
        pix(3, 0, 1, 1);
        pix(3, 1, 1, 1);
        // Mid-frame vsync carrying pixel 7 as column 0 of the new row 0.
        cur_err = 0;
        add(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c < IMG_W; c++) add(0, 0, 1, c, 0, 0, 0, 0, 0, 0, 0);
        hsy(0);
        for (int c = 0; c < IMG_W; c++) pix(1, c, 0, 0);
        hsy(1);
        for (int c = 0; c < IMG_W; c++)
            add(0, 0, 1, 20 + c, 1, 1, 0, 20 + c, 10 + c, (c == 0) ? 7 : c, c == IMG_W - 1);
        idle();
        run_tbl();

        // Async reset in the middle of row 3.
        frame(3);
        hsy(1);
        pix(3, 0, 1, 1);
        pix(3, 1, 1, 1);
        run_tbl();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        vs = 1'b0; hs = 1'b0; v = 1'b0;
        #1;
        check_zero("async_rst");
        reuse_nx = 0;
        cur_err  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        frame(3);
        idle();
        run_tbl();

        // 12 pixels with no hsync: implicit wrap every IMG_W pixels.
        vsy();
        for (int k = 0; k < 3 * IMG_W; k++) pix(k / IMG_W, k % IMG_W, k >= 2 * IMG_W, k >= 2 * IMG_W);
        idle();
        run_tbl();

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_window_3row.md
Name: line_window_3row

Overview:
- Producer side of the 3-row column stream consumed by the 3x3 max-pool and conv window stages.
- Takes a raster pixel stream (one pixel per valid cycle) and stores the previous LEN-1 lines in circular line buffers.
- Emits, per input pixel, a vertical column of LEN pixels (current row plus the rows above), with the vsync/hsync/reuse/valid sideband the window stages expect.
- Sits between the feature-map source and the pooling/conv windows.

Parameters:
- WIDTH, 27, signed pixel width.
- LEN, 3, column height (rows per output column); line buffers = LEN-1.
- IMG_W, 32, pixels per line; column counter width = clog2(IMG_W).

Ports:
- i_sclk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_vsync  in  1  1-cycle frame-start pulse.
- i_hsync  in  1  1-cycle line-start pulse, precedes first pixel of each line.
- i_valid  in  1  pixel qualifier.
- i_tdata  in  WIDTH signed  pixel.
- o_vsync  out  1  i_vsync delayed 1 cycle.
- o_hsync  out  1  gated line start (see Behaviour).
- o_reuse  out  1  end-of-output-line pulse.
- o_valid  out  1  column qualifier.
- o_tdata  out  WIDTH signed x LEN (unpacked [LEN-1:0])  column; [LEN-1]=current row, [LEN-2]=row above, ..., [0]=oldest row.
- o_err  out  1  sticky short-line flag.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; col=0, row_cnt=0, o_err=0. Line-buffer RAM is not reset; it is never emitted before being rewritten because row_cnt gates output.
- State:
  - col: 0..IMG_W-1, counts valid pixels in the current line.
  - row_cnt: 0..LEN-1, saturating count of complete lines stored.
- Priority per cycle: i_vsync > i_hsync > plain pixel.
- i_vsync: col<=0, row_cnt<=0, o_err<=0. If i_valid is also high, the pixel is written as column 0 of row 0 and col<=1. o_vsync<=1 next cycle.
- i_hsync:
  - If col!=0 (short line): o_err<=1, row_cnt unchanged, and the partial line is discarded logically (treated as overwritten).
  - In all cases col<=0; a simultaneous i_valid pixel becomes column 0 (col<=1).
  - o_hsync<=1 next cycle only if row_cnt==LEN-1 at the i_hsync cycle.
- Valid pixel at column c:
  - lb[k][c] <= lb[k-1][c] for k=LEN-2..1; lb[0][c] <= i_tdata.
  - o_tdata[LEN-1] <= i_tdata; o_tdata[LEN-2-k] <= lb[k][c] (pre-write values).
  - o_valid <= (row_cnt==LEN-1). o_tdata is held when not valid.
  - If c==IMG_W-1: col<=0 (wrap), row_cnt<=min(row_cnt+1, LEN-1), and o_reuse<=1 next cycle only if row_cnt was already LEN-1. Otherwise col<=c+1.
- Latency: exactly 1 cycle from input to o_valid/o_tdata/o_hsync/o_vsync; o_reuse is 1 cycle after the last column's o_valid.
- Non-valid cycles: no RAM write, col and row_cnt hold, o_valid=0.
- Pulse outputs (o_vsync, o_hsync, o_reuse, o_valid) are 1-cycle registered, default 0.
- More than IMG_W pixels without i_hsync: col wraps and the next line starts implicitly; no error.
- Mid-frame reset: immediate clear; the next frame must start with i_vsync, and output resumes after LEN-1 full lines.
- Gaps (i_valid low) anywhere in a line are allowed; the column index advances only on valid.
- RAM: LEN-1 arrays of IMG_W x WIDTH, single read + single write per cycle at the same address, read-before-write.

Test Plan (IMG_W=4, WIDTH=8, LEN=3; pixel value = 10*row+col):
- Frame of 4 lines, back-to-back valid after each hsync:
  - No o_valid during rows 0-1.
  - Row 2 col 1 -> o_tdata={[2]=21,[1]=11,[0]=1}.
  - Row 3 col 3 -> {33,23,13}.
  - o_hsync only for rows 2 and 3; o_reuse 1 cycle after the last valid of rows 2 and 3.
- Row 2 pixels with i_valid toggling 1/0 -> four o_valid pulses with correct columns {20,10,0}..{23,13,3}; col holds across gaps.
- i_hsync after only 2 pixels of row 1 -> o_err=1.
  - row_cnt stays 1 and the next full line acts as row 1; o_valid is first seen on the line after that.
  - o_err clears on the next i_vsync.
- i_vsync with i_valid=1 and data 7 mid-frame -> row_cnt=0, col=1, o_vsync pulse, no o_valid until 2 new full lines.
  - Then column 0 of new row 2 has [0]=7.
- Async reset asserted mid-line of row 3 -> outputs 0 immediately.
  - After release and a new frame, the first o_valid appears at row 2 col 0.
- 12 valid pixels with no i_hsync after i_vsync -> implicit wrap; o_valid starts at pixel 8; o_reuse after pixel 11; o_err=0.
